// File: rtl/circular_bist_ctrl.sv
// Circular-BIST controller: drives the CUT from a rotating test register and folds CUT outputs back into it.
// Latency: TEST_CYCLES+3 edges from start to bist_end; no backpressure, start is ignored while busy.
module circular_bist_ctrl #(
    parameter int              N_IN        = 4,
    parameter int              N_OUT       = 4,
    parameter logic [N_IN-1:0] SEED        = N_IN'(1),
    parameter int              TEST_CYCLES = 255,
    parameter logic [N_IN-1:0] GOLDEN      = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_IN-1:0] func_in,
    output logic [N_IN-1:0] cut_in,
    input  logic [N_OUT-1:0] cut_out,
    input  logic            bist_start,
    input  logic            capture_mode,
    output logic            bist_busy,
    output logic            bist_end,
    output logic            pass_fail,
    output logic [N_IN-1:0] signature
);

    localparam int CNT_W = $clog2(TEST_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TEST_CYCLES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INIT    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_COMPARE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [N_IN-1:0]  t_q, t_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cap_q, cap_d;
    logic             pass_q, pass_d;
    logic [N_IN-1:0]  sig_q, sig_d;
    logic [N_IN-1:0]  fb;

    // Outputs wider than the register fold back modulo N_IN.
    always_comb begin
        fb = '0;
        for (int j = 0; j < N_OUT; j++) begin
            fb[j % N_IN] = fb[j % N_IN] ^ cut_out[j];
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        pass_d  = pass_q;
        sig_d   = sig_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bist_start) begin
                    state_d = ST_INIT;
                    cap_d   = capture_mode;
                    pass_d  = 1'b0;
                end
            end
            ST_INIT: begin
                t_d     = SEED;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                t_d   = {t_q[N_IN-2:0], t_q[N_IN-1]} ^ fb;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                sig_d   = t_q;
                pass_d  = (t_q == GOLDEN) | cap_q;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
            pass_q  <= 1'b0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            pass_q  <= pass_d;
            sig_q   <= sig_d;
        end
    end

    assign cut_in    = (state_q == ST_RUN) ? t_q : func_in;
    assign bist_busy = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_COMPARE);
    assign bist_end  = (state_q == ST_DONE);
    assign pass_fail = pass_q;
    assign signature = sig_q;

endmodule
